// File: rtl/riscv_multicycle_ctrl.sv
// Multi-cycle RV32 control FSM: FETCH/DECODE/EXEC/MEM/WB/TRAP with decoded datapath controls.
// Optional retired-instruction counter enabled by defining RISCV_CTRL_INSTRET_EN.
module riscv_multicycle_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst,
  input  logic        mem_ready,
  input  logic        branch_taken,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        ir_we,
  output logic        pc_we,
  output logic        rf_we,
  output logic        alu_src_b,
  output logic        retire,
  output logic        illegal,
  output logic [1:0]  imm_sel,
  output logic [1:0]  pc_sel,
  output logic [1:0]  wb_sel,
  output logic [31:0] instret
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [1:0] IMM_I = 2'b00, IMM_S = 2'b01, IMM_J = 2'b10, IMM_B = 2'b11;
  localparam logic [1:0] PC_P4 = 2'b00, PC_IMM = 2'b01, PC_ALU = 2'b10;
  localparam logic [1:0] WB_ALU = 2'b00, WB_MEM = 2'b01, WB_PC4 = 2'b10;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  state_t     state;
  logic [6:0] opc;
  logic       is_op, is_op_imm, is_load, is_store, is_branch, is_jal, is_jalr, is_legal;

  // Only the opcode field steers control; the rest of the IR feeds the datapath.
  logic unused_inst;
  assign unused_inst = ^inst[31:7];

  assign opc       = inst[6:0];
  assign is_op     = (opc == OPC_OP);
  assign is_op_imm = (opc == OPC_OP_IMM);
  assign is_load   = (opc == OPC_LOAD);
  assign is_store  = (opc == OPC_STORE);
  assign is_branch = (opc == OPC_BRANCH);
  assign is_jal    = (opc == OPC_JAL);
  assign is_jalr   = (opc == OPC_JALR);
  assign is_legal  = is_op | is_op_imm | is_load | is_store | is_branch | is_jal | is_jalr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH:  if (mem_ready) state <= S_DECODE;
        S_DECODE: state <= is_legal ? S_EXEC : S_TRAP;
        S_EXEC: begin
          if (is_op || is_op_imm)                     state <= S_WB;
          else if (is_load || is_store)               state <= S_MEM;
          else if (is_branch || is_jal || is_jalr)    state <= S_FETCH;
          else                                        state <= S_TRAP;
        end
        S_MEM: if (mem_ready) state <= is_load ? S_WB : S_FETCH;
        S_WB:     state <= S_FETCH;
        S_TRAP:   state <= S_TRAP;
        default:  state <= S_TRAP;
      endcase
    end
  end

  // Controls are decoded combinationally so ir_we/retire line up with the
  // mem_ready cycle; everything is forced quiet while rst is high.
  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    rf_we        = 1'b0;
    alu_src_b    = 1'b0;
    retire       = 1'b0;
    illegal      = 1'b0;
    imm_sel      = IMM_I;
    pc_sel       = PC_P4;
    wb_sel       = WB_ALU;
    if (!rst) begin
      if (is_store)                                  imm_sel = IMM_S;
      else if (is_jal)                               imm_sel = IMM_J;
      else if (is_branch)                            imm_sel = IMM_B;
      alu_src_b = is_op_imm | is_load | is_store | is_jalr;
      case (state)
        S_FETCH: begin
          mem_req = 1'b1;
          ir_we   = mem_ready;
        end
        S_EXEC: begin
          if (is_branch) begin
            pc_we  = 1'b1;
            pc_sel = branch_taken ? PC_IMM : PC_P4;
            retire = 1'b1;
          end else if (is_jal || is_jalr) begin
            pc_we  = 1'b1;
            pc_sel = is_jal ? PC_IMM : PC_ALU;
            rf_we  = 1'b1;
            wb_sel = WB_PC4;
            retire = 1'b1;
          end
        end
        S_MEM: begin
          mem_req      = 1'b1;
          mem_addr_sel = 1'b1;
          mem_we       = is_store;
          if (mem_ready && is_store) begin
            pc_we  = 1'b1;
            retire = 1'b1;
          end
        end
        S_WB: begin
          rf_we  = 1'b1;
          wb_sel = is_load ? WB_MEM : WB_ALU;
          pc_we  = 1'b1;
          retire = 1'b1;
        end
        S_TRAP:  illegal = 1'b1;
        default: ;
      endcase
    end
  end

`ifdef RISCV_CTRL_INSTRET_EN
  logic [31:0] instret_q;

  always_ff @(posedge clk) begin
    if (rst)         instret_q <= '0;
    else if (retire) instret_q <= instret_q + 32'd1;
  end

  assign instret = rst ? '0 : instret_q;
`else
  assign instret = '0;
`endif

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Table-driven bench for riscv_multicycle_ctrl plus latency sequences with mem_ready held high.
module tb_riscv_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst;
  logic        mem_ready, branch_taken;
  logic        mem_req, mem_we, mem_addr_sel, ir_we, pc_we, rf_we, alu_src_b, retire, illegal;
  logic [1:0]  imm_sel, pc_sel, wb_sel;
  logic [31:0] instret;

  always #5 clk = ~clk;

  riscv_multicycle_ctrl dut (
    .clk(clk), .rst(rst), .inst(inst), .mem_ready(mem_ready), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .ir_we(ir_we),
    .pc_we(pc_we), .rf_we(rf_we), .alu_src_b(alu_src_b), .retire(retire), .illegal(illegal),
    .imm_sel(imm_sel), .pc_sel(pc_sel), .wb_sel(wb_sel), .instret(instret)
  );

  // Packed view: {mem_req,mem_we,mem_addr_sel,ir_we,pc_we,rf_we,alu_src_b,retire,illegal,imm,pc,wb}
  localparam logic [14:0] MREQ = 15'h4000, MWE = 15'h2000, MALU = 15'h1000, IRWE = 15'h0800;
  localparam logic [14:0] PCWE = 15'h0400, RFWE = 15'h0200, SRCB = 15'h0100, RET = 15'h0080;
  localparam logic [14:0] ILL  = 15'h0040, IS = 15'h0010, IJ = 15'h0020, IB = 15'h0030;
  localparam logic [14:0] PIMM = 15'h0004, PALU = 15'h0008, WMEM = 15'h0001, WPC = 15'h0002;

  localparam logic [31:0] ADDI = 32'h00500093, SW = 32'h00102023, BEQ = 32'h00000463;
  localparam logic [31:0] JAL = 32'h010000EF, JALR = 32'h000080E7, LW = 32'h0000A103;
  localparam logic [31:0] ADD = 32'h002081B3, BAD = 32'h00000000;

  typedef struct {
    logic        rst;
    logic [31:0] inst;
    logic        mr;
    logic        bt;
    logic [14:0] exp;
  } vec_t;

  vec_t        vecs[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [14:0] act;
  logic [31:0] exp_instret;
  int unsigned ret_cnt;

  assign act = {mem_req, mem_we, mem_addr_sel, ir_we, pc_we, rf_we, alu_src_b, retire, illegal,
                imm_sel, pc_sel, wb_sel};

  task automatic add(input logic r, input logic [31:0] i, input logic mr, input logic bt,
                     input logic [14:0] e);
    vec_t v;
    v.rst = r; v.inst = i; v.mr = mr; v.bt = bt; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic add_addi();
    add(0, ADDI, 1, 0, MREQ | IRWE | SRCB);
    add(0, ADDI, 1, 0, SRCB);
    add(0, ADDI, 1, 0, SRCB);
    add(0, ADDI, 1, 0, SRCB | RFWE | PCWE | RET);
  endtask

  // Counts cycles from the current FETCH cycle through the retire pulse.
  task automatic measure(input logic [31:0] i, input int exp_cyc, input string name);
    int n;
    logic seen;
    n = 0; seen = 1'b0;
    inst = i; mem_ready = 1'b1; branch_taken = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      #2;
      n++;
      if (retire) seen = 1'b1;
      @(negedge clk);
    end
    n_tests++;
    if (!seen || n != exp_cyc) begin
      n_fail++;
      $display("FAIL latency_%s: got %0d cycles (retire seen=%0d), expected %0d", name, n, seen, exp_cyc);
    end
  endtask

  initial begin
    // Reset, then addi walk
    add(1, ADDI, 1, 0, 15'h0);
    add(1, ADDI, 1, 0, 15'h0);
    add(0, ADDI, 0, 0, MREQ | SRCB);
    add_addi();
    // sw with two wait states in MEM
    add(0, SW, 1, 0, MREQ | IRWE | IS | SRCB);
    add(0, SW, 1, 0, IS | SRCB);
    add(0, SW, 1, 0, IS | SRCB);
    add(0, SW, 0, 0, MREQ | MWE | MALU | IS | SRCB);
    add(0, SW, 0, 0, MREQ | MWE | MALU | IS | SRCB);
    add(0, SW, 1, 0, MREQ | MWE | MALU | IS | SRCB | PCWE | RET);
    // beq taken, then not taken
    add(0, BEQ, 1, 0, MREQ | IRWE | IB);
    add(0, BEQ, 1, 0, IB);
    add(0, BEQ, 1, 1, IB | PCWE | PIMM | RET);
    add(0, BEQ, 1, 0, MREQ | IRWE | IB);
    add(0, BEQ, 1, 1, IB);
    add(0, BEQ, 1, 0, IB | PCWE | RET);
    // jal / jalr
    add(0, JAL, 1, 0, MREQ | IRWE | IJ);
    add(0, JAL, 1, 0, IJ);
    add(0, JAL, 1, 0, IJ | PCWE | PIMM | RFWE | WPC | RET);
    add(0, JALR, 1, 0, MREQ | IRWE | SRCB);
    add(0, JALR, 1, 0, SRCB);
    add(0, JALR, 1, 0, SRCB | PCWE | PALU | RFWE | WPC | RET);
    // lw with one wait state
    add(0, LW, 1, 0, MREQ | IRWE | SRCB);
    add(0, LW, 1, 0, SRCB);
    add(0, LW, 1, 0, SRCB);
    add(0, LW, 0, 0, MREQ | MALU | SRCB);
    add(0, LW, 1, 0, MREQ | MALU | SRCB);
    add(0, LW, 1, 0, SRCB | RFWE | WMEM | PCWE | RET);
    // add (register-register)
    add(0, ADD, 1, 0, MREQ | IRWE);
    add(0, ADD, 1, 0, 15'h0);
    add(0, ADD, 1, 0, 15'h0);
    add(0, ADD, 1, 0, RFWE | PCWE | RET);
    // reset in MEM of a load
    add(0, LW, 1, 0, MREQ | IRWE | SRCB);
    add(0, LW, 1, 0, SRCB);
    add(0, LW, 1, 0, SRCB);
    add(0, LW, 0, 0, MREQ | MALU | SRCB);
    add(1, LW, 1, 0, 15'h0);
    add(0, ADDI, 0, 0, MREQ | SRCB);
    for (int k = 0; k < 3; k++) add_addi();
    add(0, ADDI, 0, 0, MREQ | SRCB);
    // illegal opcode -> sticky trap, then reset recovery
    add(0, BAD, 1, 0, MREQ | IRWE);
    add(0, BAD, 1, 0, 15'h0);
    for (int k = 0; k < 12; k++) add(0, BAD, k[0], 1, ILL);
    add(1, BAD, 1, 0, 15'h0);
    add(0, ADDI, 0, 0, MREQ | SRCB);

    ret_cnt = 0;
    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; inst = vecs[i].inst;
      mem_ready = vecs[i].mr; branch_taken = vecs[i].bt;
      #2;
      n_tests++;
      if (act !== vecs[i].exp) begin
        n_fail++;
        $display("FAIL vec%0d_ctrl: got %015b, expected %015b", i, act, vecs[i].exp);
      end
`ifdef RISCV_CTRL_INSTRET_EN
      exp_instret = vecs[i].rst ? 32'd0 : ret_cnt;
`else
      exp_instret = 32'd0;
`endif
      n_tests++;
      if (instret !== exp_instret) begin
        n_fail++;
        $display("FAIL vec%0d_instret: got %0d, expected %0d", i, instret, exp_instret);
      end
      if (vecs[i].rst) ret_cnt = 0;
      else if ((vecs[i].exp & RET) != 15'h0) ret_cnt++;
      @(negedge clk);
    end

    measure(ADDI, 4, "addi");
    measure(ADD,  4, "add");
    measure(LW,   5, "lw");
    measure(SW,   4, "sw");
    measure(BEQ,  3, "beq");
    measure(JAL,  3, "jal");
    measure(JALR, 3, "jalr");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
